// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared FSM state type, clocks-per-bit floor and majority vote helper for uart_rx_param
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  localparam int MIN_CPB_DEFAULT = 4;

  function automatic logic majority3(input logic [2:0] i_bits);
    return (i_bits[0] & i_bits[1]) | (i_bits[0] & i_bits[2]) | (i_bits[1] & i_bits[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - two-flop line synchroniser followed by a 3-tap majority vote
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic i_Clock,
  input  logic rst_ni,
  input  logic i_Rx_Serial,
  output logic o_Sync,
  output logic o_Vote
);

  logic       r_sync1;
  logic       r_sync2;
  logic [2:0] r_hist;

  // Synchronise the async line and keep the last three synchronised values; idle level is 1.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 3'b111;
    end else begin
      r_sync1 <= i_Rx_Serial;
      r_sync2 <= r_sync1;
      r_hist  <= {r_hist[1:0], r_sync2};
    end
  end

  assign o_Sync = r_sync2;
  assign o_Vote = majority3(r_hist);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with holding register; parity optional via UART_RX_PARITY_EN
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16,
  parameter int MIN_CPB   = MIN_CPB_DEFAULT
) (
  input  logic                 i_Clock,
  input  logic                 rst_ni,
  input  logic                 i_Rx_Serial,
  input  logic [DIV_W-1:0]     i_Clks_Per_Bit,
  input  logic                 i_Two_Stop,
  input  logic                 i_Parity_En,
  input  logic                 i_Parity_Odd,
  input  logic                 i_Rx_Ready,
  output logic                 o_Rx_Valid,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Overrun
);

  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] CPB_MIN  = DIV_W'(MIN_CPB);
  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);

  rx_state_e r_state, w_next_state;

  logic                 w_sync, w_vote;
  logic [DIV_W-1:0]     r_count, r_cpb, w_cpb_in;
  logic [3:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_two_stop, r_stop_idx, r_stop_any0, r_stop_all0;
  logic                 w_at_half, w_at_end, w_sample, w_done;
  logic                 w_stop_any0, w_stop_all0, w_is_break;
  logic                 w_word_ok, w_frame_det, w_break_det;
  logic                 w_par_bit, w_perr;
  logic                 r_valid, r_perr, r_frame_err, r_break, r_overrun;
  logic [DATA_BITS-1:0] r_data;

  uart_rx_sampler u_sampler (
    .i_Clock     (i_Clock),
    .rst_ni      (rst_ni),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Sync      (w_sync),
    .o_Vote      (w_vote)
  );

  assign w_cpb_in  = (i_Clks_Per_Bit < CPB_MIN) ? CPB_MIN : i_Clks_Per_Bit;
  assign w_at_half = (r_count == ((r_cpb - ONE) >> 1));
  assign w_at_end  = (r_count == (r_cpb - ONE));

`ifdef UART_RX_PARITY_EN
  logic r_par_en, r_par_odd, r_par_bit;

  // Parity configuration is frozen at start detect; the parity sample is kept for the break check.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (r_state == IDLE && w_next_state == START) begin
      r_par_en  <= i_Parity_En;
      r_par_odd <= i_Parity_Odd;
      r_par_bit <= 1'b0;
    end else if (r_state == PARITY && w_sample) begin
      r_par_bit <= w_vote;
    end
  end

  assign w_par_bit = r_par_bit;
  assign w_perr    = r_par_en & ((^r_shift ^ r_par_bit) != r_par_odd);
`else
  logic w_unused_parity;
  assign w_unused_parity = i_Parity_En ^ i_Parity_Odd;
  assign w_par_bit       = 1'b0;
  assign w_perr          = 1'b0;
`endif

  // Stop-bit outcome including the sample being taken this cycle.
  assign w_stop_any0 = r_stop_any0 | ~w_vote;
  assign w_stop_all0 = r_stop_all0 & ~w_vote;
  assign w_is_break  = (r_shift == '0) & ~w_par_bit & w_stop_all0;
  assign w_word_ok   = w_done & ~w_stop_any0;
  assign w_frame_det = w_done & w_stop_any0 & ~w_is_break;
  assign w_break_det = w_done & w_is_break;

  // FSM state register.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic and sample/frame-complete strobes.
  always_comb begin
    w_next_state = r_state;
    w_sample     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE:     if (!w_sync) w_next_state = START;
      START:    if (w_at_half) w_next_state = w_vote ? IDLE : DATA;
      DATA: begin
        if (w_at_end) begin
          w_sample = 1'b1;
          if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            w_next_state = r_par_en ? PARITY : STOP;
`else
            w_next_state = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_at_end) begin
          w_sample     = 1'b1;
          w_next_state = STOP;
        end
      end
`endif
      STOP: begin
        if (w_at_end) begin
          w_sample = 1'b1;
          if (!(r_two_stop && !r_stop_idx)) begin
            w_done       = 1'b1;
            w_next_state = w_is_break ? BRK_WAIT : IDLE;
          end
        end
      end
      BRK_WAIT: if (w_sync) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Bit-period counter, shift register and per-frame bookkeeping.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count     <= '0;
      r_cpb       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_two_stop  <= 1'b0;
      r_stop_idx  <= 1'b0;
      r_stop_any0 <= 1'b0;
      r_stop_all0 <= 1'b1;
    end else begin
      if (w_next_state != r_state || w_sample || r_state == IDLE || r_state == BRK_WAIT)
        r_count <= '0;
      else
        r_count <= r_count + ONE;

      if (r_state == IDLE && w_next_state == START) begin
        r_cpb       <= w_cpb_in;
        r_two_stop  <= i_Two_Stop;
        r_bit_idx   <= '0;
        r_stop_idx  <= 1'b0;
        r_stop_any0 <= 1'b0;
        r_stop_all0 <= 1'b1;
      end

      if (r_state == DATA && w_sample) begin
        r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
        r_bit_idx <= r_bit_idx + 4'd1;
      end

      if (r_state == STOP && w_sample) begin
        r_stop_idx  <= 1'b1;
        r_stop_any0 <= w_stop_any0;
        r_stop_all0 <= w_stop_all0;
      end
    end
  end

  // Holding register with valid/ready handshake and one-cycle status pulses.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_perr      <= 1'b0;
      r_frame_err <= 1'b0;
      r_break     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_det;
      r_break     <= w_break_det;
      r_overrun   <= 1'b0;
      if (w_word_ok) begin
        if (!r_valid || i_Rx_Ready) begin
          r_valid <= 1'b1;
          r_data  <= r_shift;
          r_perr  <= w_perr;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_Rx_Ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_Rx_Valid  = r_valid;
  assign o_Rx_Data   = r_data;
  assign o_Frame_Err = r_frame_err;
  assign o_Break     = r_break;
  assign o_Overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = r_perr;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param (parity cases only when UART_RX_PARITY_EN is defined)
module tb_uart_rx_param;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        rx;
  logic [15:0] cpb;
  logic        two_stop, par_en, par_odd, ready;
  logic        valid, perr, ferr, brk, ovr;
  logic [7:0]  data;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_vcyc   = 0;
  int n_fe     = 0;
  int n_brk    = 0;
  int n_ovr    = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_word;

  always #5 clk = ~clk;

  uart_rx_param dut (
    .i_Clock        (clk),
    .rst_ni         (rst_ni),
    .i_Rx_Serial    (rx),
    .i_Clks_Per_Bit (cpb),
    .i_Two_Stop     (two_stop),
    .i_Parity_En    (par_en),
    .i_Parity_Odd   (par_odd),
    .i_Rx_Ready     (ready),
    .o_Rx_Valid     (valid),
    .o_Rx_Data      (data),
    .o_Parity_Err   (perr),
    .o_Frame_Err    (ferr),
    .o_Break        (brk),
    .o_Overrun      (ovr)
  );

  // Output monitor: counts pulses and pops the scoreboard on every accepted word.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (ferr)  n_fe++;
      if (brk)   n_brk++;
      if (ovr)   n_ovr++;
      if (valid) n_vcyc++;
      if (valid && ready) begin
        n_valid++;
        n_checks++;
        if (exp_q.size() == 0) begin
          assert (0) else begin
            n_errors++;
            $error("FAIL unexpected_word observed=%0h expected=none", data);
          end
        end else begin
          exp_word = exp_q.pop_front();
          assert ({perr, data} === exp_word) else begin
            n_errors++;
            $error("FAIL word observed=%0h expected=%0h", {perr, data}, exp_word);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input int clks);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (clks) @(posedge clk);
    end
  endtask

  task automatic line(input logic v, input int clks);
    rx = v;
    repeat (clks) @(posedge clk);
  endtask

  initial begin
    rst_ni = 1'b0; rx = 1'b1; cpb = 16'd16; two_stop = 1'b0;
    par_en = 1'b0; par_odd = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_data",  {24'd0, data}, 32'd0);
    chk("reset_pulses", {28'd0, perr, ferr, brk, ovr}, 32'd0);
    rst_ni = 1'b1;
    line(1'b1, 10);

    // 8N1 0xA5 with ready held high: one word, valid for one cycle.
    exp_q.push_back({1'b0, 8'hA5});
    send_bits({6'd0, 1'b1, 8'hA5, 1'b0}, 10, 16);
    line(1'b1, 20);
    chk("a5_count", n_valid, 1);
    chk("a5_one_cycle", n_vcyc, 1);
    chk("a5_no_errs", n_fe + n_brk + n_ovr, 0);

    // Short low glitch is rejected at mid start bit.
    line(1'b0, 3);
    line(1'b1, 40);
    chk("glitch_no_word", n_valid, 1);
    chk("glitch_no_errs", n_fe + n_brk, 0);

    // Two words without accept: first held, second dropped with one overrun pulse.
    ready = 1'b0;
    exp_q.push_back({1'b0, 8'h3C});
    send_bits({6'd0, 1'b1, 8'h3C, 1'b0}, 10, 16);
    line(1'b1, 20);
    send_bits({6'd0, 1'b1, 8'h5A, 1'b0}, 10, 16);
    line(1'b1, 20);
    @(negedge clk);
    chk("held_valid", {31'd0, valid}, 32'd1);
    chk("held_data", {24'd0, data}, 32'h3C);
    chk("overrun_once", n_ovr, 1);
    ready = 1'b1;
    line(1'b1, 4);
    chk("drain_count", n_valid, 2);
    chk("drain_valid_low", {31'd0, valid}, 32'd0);

    // 0x81 with stop bit low: frame error, no word.
    send_bits({7'd0, 8'h81, 1'b0}, 9, 16);
    line(1'b0, 11);
    line(1'b1, 40);
    chk("ferr_pulse", n_fe, 1);
    chk("ferr_no_word", n_valid, 2);
    chk("ferr_no_break", n_brk, 0);

    // Long break: single break pulse, no frame error; then 0x55 received.
    line(1'b0, 320);
    line(1'b1, 40);
    chk("break_pulse", n_brk, 1);
    chk("break_no_ferr", n_fe, 1);
    exp_q.push_back({1'b0, 8'h55});
    send_bits({6'd0, 1'b1, 8'h55, 1'b0}, 10, 16);
    line(1'b1, 20);
    chk("after_break_word", n_valid, 3);

    // Two stop bits: good frame, then second stop low gives a frame error.
    two_stop = 1'b1;
    exp_q.push_back({1'b0, 8'hC3});
    send_bits({5'd0, 2'b11, 8'hC3, 1'b0}, 11, 16);
    line(1'b1, 20);
    chk("two_stop_word", n_valid, 4);
    send_bits({5'd0, 1'b1, 8'hC3, 1'b0}, 10, 16);
    line(1'b0, 11);
    line(1'b1, 40);
    chk("two_stop_ferr", n_fe, 2);
    chk("two_stop_no_word", n_valid, 4);
    two_stop = 1'b0;

    // Divisor below the floor is clamped to 4 clocks per bit.
    cpb = 16'd1;
    exp_q.push_back({1'b0, 8'h96});
    send_bits({6'd0, 1'b1, 8'h96, 1'b0}, 10, 4);
    line(1'b1, 20);
    chk("clamp_word", n_valid, 5);
    cpb = 16'd16;

    // All-zero data with a good stop is an ordinary word, not a break.
    exp_q.push_back({1'b0, 8'h00});
    send_bits({6'd0, 1'b1, 8'h00, 1'b0}, 10, 16);
    line(1'b1, 20);
    chk("zero_word", n_valid, 6);
    chk("zero_no_break", n_brk, 1);

    // Reset in the middle of the data bits aborts the frame silently.
    send_bits({12'd0, 4'b1010}, 4, 16);
    rx = 1'b1;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    rst_ni = 1'b1;
    line(1'b1, 200);
    chk("rst_mid_valid", {31'd0, valid}, 32'd0);
    chk("rst_mid_counts", n_valid + n_fe + n_brk + n_ovr, 6 + 2 + 1 + 1);

`ifdef UART_RX_PARITY_EN
    // Odd parity: 0x07 with parity bit 1 carries an even total, so the word is flagged.
    par_en = 1'b1; par_odd = 1'b1;
    exp_q.push_back({1'b1, 8'h07});
    send_bits({5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 16);
    line(1'b1, 20);
    chk("parity_word", n_valid, 7);
    exp_q.push_back({1'b0, 8'h07});
    send_bits({5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 16);
    line(1'b1, 20);
    chk("parity_ok_word", n_valid, 8);
    par_en = 1'b0;
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("overrun_total", n_ovr, 1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
